// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_four_bit_if.sv
// Request/result bundle of the divider.
// The requester drives start and operands; the divider returns results.
interface div_four_bit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/div_four_bit_sub.sv
// N-bit trial subtractor: a - b as a + ~b + 1.
// borrow_o is high when b > a (no carry out of the top bit).
module sub_n_bit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] sum;

    assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};
    assign diff_o   = sum[N-1:0];
    assign borrow_o = ~sum[N];

endmodule

// File: rtl/div_four_bit.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Quotient bits shift into the dividend register as it empties.
module div_four_bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    div_four_bit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic             unused_diff_msb;

    assign trial = {rem_q, dvd_q[WIDTH-1]};

    sub_n_bit #(
        .N(WIDTH + 1)
    ) u_sub (
        .a_i      (trial),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // A successful subtraction always leaves a value below the divisor,
    // so the top difference bit carries no information.
    assign unused_diff_msb = diff[WIDTH];

    assign step_rem = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_dvd = {dvd_q[WIDTH-2:0], ~borrow};

    // Next-state and datapath update for IDLE/RUN/DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = step_dvd;
                    rmd_d   = step_rem;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_div_four_bit.sv
// Bench for div_four_bit: cycle-level reference model built on / and %,
// compared against the DUT every cycle, plus directed literal checks.
module tb_div_four_bit;

    logic clk = 1'b0;
    logic rst;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    div_four_bit_if #(.WIDTH(4)) bus ();

    div_four_bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt = 0;
    bit m_done = 1'b0;
    int m_q = 0;
    int m_r = 0;
    int m_dbz = 0;
    int pq = 0;
    int pr = 0;
    int m_dones = 0;
    int m_accepts = 0;
    int dut_dones = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a division takes 4 RUN cycles then 1 DONE cycle;
    // divide by zero goes straight to the DONE cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_q    = 0;
            m_r    = 0;
            m_dbz  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_dones++;
                m_q = pq;
                m_r = pr;
            end
        end else if (bus.start === 1'b1) begin
            m_accepts++;
            if (bus.divisor == 4'd0) begin
                m_done = 1'b1;
                m_dones++;
                m_q   = 15;
                m_r   = int'(bus.dividend);
                m_dbz = 1;
            end else begin
                m_cnt = 4;
                pq    = int'(bus.dividend) / int'(bus.divisor);
                pr    = int'(bus.dividend) % int'(bus.divisor);
                m_dbz = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", bus.busy, (m_cnt > 0) ? 1 : 0);
            chk("done", bus.done, m_done ? 1 : 0);
            chk("quotient", bus.quotient, m_q);
            chk("remainder", bus.remainder, m_r);
            chk("div_by_zero", bus.div_by_zero, m_dbz);
            if (bus.done === 1'b1) dut_dones++;
        end
    end

    task automatic run_div(input int a, input int b, input int eq,
                           input int er, input int ed);
        int k;
        int nbusy;
        nbusy = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a[3:0];
        bus.divisor  = b[3:0];
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 4'($urandom_range(15, 0));
        bus.divisor  = 4'($urandom_range(15, 0));
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            k++;
        end
        chk("done_seen", bus.done, 1);
        chk("latency", k, (b == 0) ? 0 : 4);
        chk("busy_cycles", nbusy, (b == 0) ? 0 : 4);
        chk("lit_q", bus.quotient, eq);
        chk("lit_r", bus.remainder, er);
        chk("lit_dbz", bus.div_by_zero, ed);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int d0;
        int a0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor  = 4'd0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;

        run_div(13, 3, 4, 1, 0);
        run_div(7, 0, 15, 7, 1);
        run_div(15, 1, 15, 0, 0);
        run_div(3, 5, 0, 3, 0);
        run_div(15, 15, 1, 0, 0);
        run_div(0, 9, 0, 0, 0);

        // Start during RUN is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ign_done_seen", bus.done, 1);
        chk("ign_q", bus.quotient, 4);
        chk("ign_r", bus.remainder, 1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        chk("ign_extra_done", n, 0);

        // Reset in the second RUN cycle aborts without done
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_q", bus.quotient, 0);
        chk("abort_r", bus.remainder, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        chk("abort_no_done", n, 0);
        run_div(6, 4, 1, 2, 0);

        // All operand pairs
        @(negedge clk);
        #1;
        d0 = dut_dones;
        a0 = m_accepts;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a, b, (b == 0) ? 15 : a / b,
                        (b == 0) ? a : a % b, (b == 0) ? 1 : 0);
            end
        end
        @(negedge clk);
        #1;
        chk("exh_dones", dut_dones - d0, 256);
        chk("exh_accepts", m_accepts - a0, 256);

        // Back-to-back with start held high
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 4'd1;
        n = 0;
        repeat (18) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        bus.start = 1'b0;
        chk("b2b_dones", n, 3);
        chk("b2b_q", bus.quotient, 15);
        repeat (8) @(negedge clk);

        // Random traffic including resets and held start
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.start    = (i >= 400) ? 1'b1 : ($urandom_range(2, 0) == 0);
            bus.dividend = 4'($urandom_range(15, 0));
            bus.divisor  = ($urandom_range(4, 0) == 0) ? 4'd0
                                                        : 4'($urandom_range(15, 0));
            rst          = ($urandom_range(59, 0) == 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("total_dones", dut_dones, m_dones);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
